// File: rtl/psum_acc_pkg.sv
// rtl/psum_acc_pkg.sv - shared state encoding and saturation helper for the psum buffer
package psum_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Working width for saturation math; wide enough for any lane sum we build.
    localparam int SAT_W = 64;

    // Clamp a signed value into the range of an n-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int unsigned            n);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// rtl/psum_acc_lane.sv - per-lane extend/accumulate/saturate and ReLU output clamp
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20
) (
    input  logic signed [PSUM_BW-1:0] in_lane,
    input  logic signed [ACC_BW-1:0]  acc,
    input  logic                      first,
    input  logic                      relu,
    output logic signed [ACC_BW-1:0]  acc_next,
    output logic                      sat_hit,
    output logic signed [PSUM_BW-1:0] out_lane
);

    logic signed [SAT_W-1:0] in_ext;
    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] sum_sat;
    logic signed [SAT_W-1:0] relu_val;

    // First pass overwrites with the extended input; later passes add and clamp.
    always_comb begin
        in_ext   = {{(SAT_W-PSUM_BW){in_lane[PSUM_BW-1]}}, in_lane};
        acc_ext  = {{(SAT_W-ACC_BW){acc[ACC_BW-1]}}, acc};
        sum      = acc_ext + in_ext;
        sum_sat  = sat(sum, ACC_BW);
        acc_next = first ? ACC_BW'(in_ext) : ACC_BW'(sum_sat);
        sat_hit  = !first && (sum_sat != sum);
        relu_val = (relu && (acc_ext < 0)) ? '0 : acc_ext;
        out_lane = PSUM_BW'(sat(relu_val, PSUM_BW));
    end

endmodule

// File: rtl/psum_accum_buffer.sv
// rtl/psum_accum_buffer.sv - multi-pass psum accumulation buffer with saturating drain
module psum_accum_buffer
    import psum_acc_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20,
    parameter int DEPTH   = 64,
    parameter int AW      = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [AW-1:0]            len,
    input  logic [7:0]               npass,
    input  logic                     relu_en,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*PSUM_BW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*PSUM_BW-1:0]   out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     sat_flag
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t               state;
    logic [AW-1:0]        len_q;
    logic [7:0]           npass_q;
    logic                 relu_q;
    logic [AW-1:0]        w;
    logic [AW-1:0]        r;
    logic [7:0]           p;

    logic [COL*ACC_BW-1:0]  mem [DEPTH];
    logic [IW-1:0]          rd_idx;
    logic [COL*ACC_BW-1:0]  rd_word;
    logic [COL*ACC_BW-1:0]  wr_word;
    logic [COL*PSUM_BW-1:0] out_word;
    logic [COL-1:0]         lane_sat;

    logic cfg_ok;
    logic in_fire;
    logic last_word;
    logic last_pass;
    logic out_load;
    logic out_fire;

    // One shared read port: the write target while accumulating, the drain pointer otherwise.
    assign rd_idx    = (state == ST_DRAIN) ? r[IW-1:0] : w[IW-1:0];
    assign rd_word   = mem[rd_idx];

    assign cfg_ok    = (len != '0) && (len <= AW'(DEPTH)) && (npass != 8'd0);
    assign in_fire   = in_ready && in_valid && !abort;
    assign last_word = (w == len_q - 1'b1);
    assign last_pass = (p == npass_q - 8'd1);
    assign out_load  = (r < len_q) && (!out_valid || out_ready);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);

    for (genvar k = 0; k < COL; k++) begin : g_lane
        psum_acc_lane #(
            .PSUM_BW (PSUM_BW),
            .ACC_BW  (ACC_BW)
        ) u_lane (
            .in_lane  (in_data[k*PSUM_BW +: PSUM_BW]),
            .acc      (rd_word[k*ACC_BW +: ACC_BW]),
            .first    (p == 8'd0),
            .relu     (relu_q),
            .acc_next (wr_word[k*ACC_BW +: ACC_BW]),
            .sat_hit  (lane_sat[k]),
            .out_lane (out_word[k*PSUM_BW +: PSUM_BW])
        );
    end

    // Accumulator array write; intentionally not reset, pass 0 overwrites every live entry.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[w[IW-1:0]] <= wr_word;
        end
    end

    // Control FSM with counters and registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            npass_q   <= '0;
            relu_q    <= 1'b0;
            w         <= '0;
            r         <= '0;
            p         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                in_ready  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                len_q    <= len;
                                npass_q  <= npass;
                                relu_q   <= relu_en;
                                w        <= '0;
                                p        <= '0;
                                sat_flag <= 1'b0;
                                in_ready <= 1'b1;
                                state    <= ST_ACCUM;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (in_fire) begin
                            if (|lane_sat) begin
                                sat_flag <= 1'b1;
                            end
                            if (last_word) begin
                                w <= '0;
                                p <= p + 8'd1;
                                if (last_pass) begin
                                    in_ready <= 1'b0;
                                    r        <= '0;
                                    state    <= ST_DRAIN;
                                end
                            end else begin
                                w <= w + 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_load) begin
                            out_data  <= out_word;
                            out_valid <= 1'b1;
                            r         <= r + 1'b1;
                        end else if ((r == len_q) && out_fire) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// tb/tb_psum_accum_buffer.sv - randomized self-checking bench for psum_accum_buffer
module tb_psum_accum_buffer;

    localparam int COL     = 4;
    localparam int PSUM_BW = 16;
    localparam int ACC_BW  = 20;
    localparam int DEPTH   = 16;
    localparam int AW      = $clog2(DEPTH) + 1;
    localparam int VW      = COL * PSUM_BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] len;
    logic [7:0]    npass;
    logic          relu_en;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          sat_flag;

    int     total = 0;
    int     bad   = 0;
    longint ref_acc [DEPTH][COL];
    bit     exp_sat;

    always #5 clk = ~clk;

    psum_accum_buffer #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW),
        .ACC_BW  (ACC_BW),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .npass     (npass),
        .relu_en   (relu_en),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .sat_flag  (sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input int n);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (n - 1)) - 1;
        lo = -(longint'(1) <<< (n - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // mode 0: random lanes, 1: every lane = cval, 2: every lane = word index + 1
    function automatic logic [VW-1:0] gen_vec(input int mode, input int cval, input int w);
        logic [VW-1:0]      v;
        logic [PSUM_BW-1:0] e;
        v = '0;
        for (int k = 0; k < COL; k++) begin
            case (mode)
                0:       e = PSUM_BW'($urandom);
                1:       e = PSUM_BW'(cval);
                default: e = PSUM_BW'(w + 1);
            endcase
            v[k*PSUM_BW +: PSUM_BW] = e;
        end
        return v;
    endfunction

    task automatic run(input int l, input int np, input int relu, input int mode, input int cval,
                       input int bp, input int gaps, input int abort_p, input int rst_drain);
        logic [VW-1:0] v;
        logic [VW-1:0] stall_data;
        logic [VW-1:0] ev [DEPTH];
        int            got_n;
        int            cyc;
        bit            stalled;
        @(negedge clk);
        start   = 1'b1;
        len     = AW'(l);
        npass   = 8'(np);
        relu_en = relu[0];
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", in_ready, 1);
        check("start_busy", busy, 1);
        exp_sat = 1'b0;
        for (int p = 0; p < np; p++) begin
            for (int w = 0; w < l; w++) begin
                if (p == abort_p && w == 0) begin
                    abort    = 1'b1;
                    in_valid = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_idle", busy, 0);
                    check("abort_in_ready", in_ready, 0);
                    check("abort_no_done", done, 0);
                    check("abort_sat_kept", sat_flag, exp_sat);
                    @(negedge clk);
                    check("abort_no_done2", done, 0);
                    return;
                end
                if (gaps != 0) begin
                    while ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                v        = gen_vec(mode, cval, w);
                in_data  = v;
                in_valid = 1'b1;
                for (int k = 0; k < COL; k++) begin
                    longint x;
                    longint s;
                    longint c;
                    x = longint'($signed(v[k*PSUM_BW +: PSUM_BW]));
                    if (p == 0) begin
                        ref_acc[w][k] = x;
                    end else begin
                        s = ref_acc[w][k] + x;
                        c = clamp(s, ACC_BW);
                        if (c != s) exp_sat = 1'b1;
                        ref_acc[w][k] = c;
                    end
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        for (int w = 0; w < l; w++) begin
            for (int k = 0; k < COL; k++) begin
                longint y;
                y = ref_acc[w][k];
                if (relu != 0 && y < 0) y = 0;
                ev[w][k*PSUM_BW +: PSUM_BW] = PSUM_BW'(clamp(y, PSUM_BW));
            end
        end
        check("drain_lat1", out_valid, 0);
        @(negedge clk);
        check("first_valid", out_valid, 1);
        if (rst_drain != 0) begin
            out_ready = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_out_data", out_data, 0);
            @(negedge clk);
            reset   = 1'b0;
            exp_sat = 1'b0;
            return;
        end
        got_n   = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (got_n < l && cyc < 4 * l + 20) begin
            if (stalled) check("stall_stable", out_data, stall_data);
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                check($sformatf("beat%0d", got_n), out_data, ev[got_n]);
                got_n++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled    = 1'b1;
                stall_data = out_data;
            end
            cyc++;
            @(negedge clk);
        end
        if (got_n < l) check("drain_timeout", got_n, l);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_out_valid", out_valid, 0);
        check("sat_flag", sat_flag, exp_sat);
        out_ready = 1'b0;
        @(negedge clk);
        check("done_once", done, 0);
    endtask

    task automatic bad_cfg(input int l, input int np);
        @(negedge clk);
        start = 1'b1;
        len   = AW'(l);
        npass = 8'(np);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("cfg_err_l%0d_n%0d", l, np), cfg_err, 1);
        check("cfg_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        npass     = '0;
        relu_en   = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid0", out_valid, 0);
        check("rst_out_data0", out_data, 0);
        check("rst_busy0", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_sat_flag", sat_flag, 0);
        reset = 1'b0;

        run(4, 1, 0, 2, 0, 0, 0, -1, 0);
        run(2, 3, 0, 1, 100, 0, 0, -1, 0);
        run(2, 3, 1, 1, -50, 0, 0, -1, 0);
        run(2, 40, 0, 1, 32767, 0, 0, -1, 0);
        run(2, 40, 0, 1, -32768, 0, 0, -1, 0);
        run(DEPTH, 2, 0, 0, 0, 1, 0, -1, 0);

        bad_cfg(0, 1);
        bad_cfg(DEPTH + 1, 1);
        bad_cfg(4, 0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        len   = AW'(2);
        npass = 8'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 0);
        check("abort_start_no_err", cfg_err, 0);

        run(3, 3, 0, 0, 0, 0, 0, 1, 0);
        run(3, 2, 1, 0, 0, 2, 1, -1, 0);
        run(5, 2, 0, 0, 0, 0, 0, -1, 1);
        run(5, 2, 0, 1, 20000, 2, 1, -1, 0);

        for (int i = 0; i < 8; i++) begin
            run($urandom_range(1, DEPTH), $urandom_range(1, 4), $urandom_range(0, 1),
                0, 0, $urandom_range(0, 2), 1, -1, 0);
        end
        run(3, 30, 1, 1, -30000, 2, 1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
